// File: rtl/riscv_axi_pkg.sv
// Shared types and helpers for the core-to-DRAM AXI window bridge.
// Window arithmetic is done on full 32-bit masks so the split point can be a parameter.
package riscv_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP,
        W_ERR,
        W_ERESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_ERR
    } rd_state_e;

    function automatic logic [31:0] win_mask(input int bits);
        return ~((32'd1 << bits) - 32'd1);
    endfunction

    function automatic logic win_hit(input logic [31:0] addr, input logic [31:0] base,
                                     input int bits);
        return (addr & win_mask(bits)) == (base & win_mask(bits));
    endfunction

    function automatic logic [31:0] win_remap(input logic [31:0] addr, input logic [31:0] base,
                                              input int bits);
        return (base & win_mask(bits)) | (addr & ~win_mask(bits));
    endfunction

endpackage

// File: rtl/riscv_axi_err_rd_gen.sv
// DECERR read-beat generator: emits len+1 error beats for a rejected read burst.
module riscv_axi_err_rd_gen
    import riscv_axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] len_i,
    input  logic       active_i,
    input  logic       rready_i,
    output logic       rvalid_o,
    output logic       rlast_o,
    output logic       done_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = len_i;
        end else if (active_i && rready_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rvalid_o = active_i;
    assign rlast_o  = active_i && (cnt_q == 8'd0);
    assign done_o   = active_i && rready_i && (cnt_q == 8'd0);

endmodule

// File: rtl/riscv_axi_dram_window.sv
// Remaps core AXI bursts in the core memory window onto the DRAM window; misses get DECERR locally.
// Write: W_IDLE accept | W_ADDR issue AW | W_DATA pass W | W_RESP pass B | W_ERR sink W | W_ERESP DECERR B
`ifndef RISCV_DRAM_BASE
`define RISCV_DRAM_BASE 32'h3E00_0000
`endif
`ifndef RISCV_DRAM_BITS
`define RISCV_DRAM_BITS 24
`endif

module riscv_axi_dram_window
    import riscv_axi_pkg::*;
#(
    parameter logic [31:0] C_CORE_BASE  = 32'h8000_0000,
    parameter logic [31:0] C_DRAM_BASE  = `RISCV_DRAM_BASE,
    parameter int          C_DRAM_BITS  = `RISCV_DRAM_BITS,
    parameter int          C_ID_WIDTH   = 6,
    parameter int          C_ADDR_WIDTH = 32,
    parameter int          C_DATA_WIDTH = 64
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_aresetn,

    input  logic [C_ID_WIDTH-1:0]     s_awid,
    input  logic [C_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]                s_awlen,
    input  logic [2:0]                s_awsize,
    input  logic [1:0]                s_awburst,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [C_DATA_WIDTH-1:0]   s_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                      s_wlast,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [C_ID_WIDTH-1:0]     s_bid,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [C_ID_WIDTH-1:0]     s_arid,
    input  logic [C_ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]                s_arlen,
    input  logic [2:0]                s_arsize,
    input  logic [1:0]                s_arburst,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [C_ID_WIDTH-1:0]     s_rid,
    output logic [C_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rlast,
    output logic                      s_rvalid,
    input  logic                      s_rready,

    output logic [C_ID_WIDTH-1:0]     m_awid,
    output logic [C_ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [C_DATA_WIDTH-1:0]   m_wdata,
    output logic [C_DATA_WIDTH/8-1:0] m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [C_ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [C_ID_WIDTH-1:0]     m_arid,
    output logic [C_ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [C_ID_WIDTH-1:0]     m_rid,
    input  logic [C_DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast,
    input  logic                      m_rvalid,
    output logic                      m_rready,

    output logic                      dec_err
);

    wr_state_e w_state_q, w_state_d;
    rd_state_e r_state_q, r_state_d;

    // Holds the address readies low through reset and releases them on the first clock after.
    logic rdy_q;
    logic dec_err_q;

    logic [C_ID_WIDTH-1:0]   aw_id_q, ar_id_q;
    logic [C_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [7:0]              aw_len_q, ar_len_q;
    logic [2:0]              aw_size_q, ar_size_q;
    logic [1:0]              aw_burst_q, ar_burst_q;

    logic aw_hs, ar_hs, aw_hit, ar_hit;
    logic err_rvalid, err_rlast, err_done;

    assign aw_hs  = s_awvalid && s_awready;
    assign ar_hs  = s_arvalid && s_arready;
    assign aw_hit = win_hit(s_awaddr, C_CORE_BASE, C_DRAM_BITS);
    assign ar_hit = win_hit(s_araddr, C_CORE_BASE, C_DRAM_BITS);
    assign dec_err = dec_err_q;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            rdy_q      <= 1'b0;
            dec_err_q  <= 1'b0;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            rdy_q     <= 1'b1;
            // A write miss and a read miss in the same cycle merge into one pulse.
            dec_err_q <= (aw_hs && !aw_hit) || (ar_hs && !ar_hit);
            if (aw_hs) begin
                aw_id_q    <= s_awid;
                aw_addr_q  <= s_awaddr;
                aw_len_q   <= s_awlen;
                aw_size_q  <= s_awsize;
                aw_burst_q <= s_awburst;
            end
            if (ar_hs) begin
                ar_id_q    <= s_arid;
                ar_addr_q  <= s_araddr;
                ar_len_q   <= s_arlen;
                ar_size_q  <= s_arsize;
                ar_burst_q <= s_arburst;
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bid     = '0;
        s_bresp   = RESP_OKAY;
        s_bvalid  = 1'b0;
        m_awid    = '0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awsize  = '0;
        m_awburst = '0;
        m_awvalid = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                s_awready = rdy_q;
                if (aw_hs) begin
                    w_state_d = aw_hit ? W_ADDR : W_ERR;
                end
            end
            W_ADDR: begin
                m_awvalid = 1'b1;
                m_awid    = aw_id_q;
                m_awaddr  = win_remap(aw_addr_q, C_DRAM_BASE, C_DRAM_BITS);
                m_awlen   = aw_len_q;
                m_awsize  = aw_size_q;
                m_awburst = aw_burst_q;
                if (m_awready) begin
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                m_wvalid = s_wvalid;
                m_wdata  = s_wdata;
                m_wstrb  = s_wstrb;
                m_wlast  = s_wlast;
                s_wready = m_wready;
                if (s_wvalid && m_wready && s_wlast) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                s_bvalid = m_bvalid;
                s_bid    = m_bid;
                s_bresp  = m_bresp;
                m_bready = s_bready;
                if (m_bvalid && s_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            W_ERR: begin
                s_wready = 1'b1;
                if (s_wvalid && s_wlast) begin
                    w_state_d = W_ERESP;
                end
            end
            W_ERESP: begin
                s_bvalid = 1'b1;
                s_bresp  = RESP_DECERR;
                s_bid    = aw_id_q;
                if (s_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    riscv_axi_err_rd_gen u_err_rd_gen (
        .clk      (m_axi_aclk),
        .rst_n    (m_axi_aresetn),
        .load_i   (ar_hs && !ar_hit),
        .len_i    (s_arlen),
        .active_i (r_state_q == R_ERR),
        .rready_i (s_rready),
        .rvalid_o (err_rvalid),
        .rlast_o  (err_rlast),
        .done_o   (err_done)
    );

    always_comb begin
        r_state_d = r_state_q;
        s_arready = 1'b0;
        s_rid     = '0;
        s_rdata   = '0;
        s_rresp   = RESP_OKAY;
        s_rlast   = 1'b0;
        s_rvalid  = 1'b0;
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                s_arready = rdy_q;
                if (ar_hs) begin
                    r_state_d = ar_hit ? R_ADDR : R_ERR;
                end
            end
            R_ADDR: begin
                m_arvalid = 1'b1;
                m_arid    = ar_id_q;
                m_araddr  = win_remap(ar_addr_q, C_DRAM_BASE, C_DRAM_BITS);
                m_arlen   = ar_len_q;
                m_arsize  = ar_size_q;
                m_arburst = ar_burst_q;
                if (m_arready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                s_rvalid = m_rvalid;
                s_rid    = m_rid;
                s_rdata  = m_rdata;
                s_rresp  = m_rresp;
                s_rlast  = m_rlast;
                m_rready = s_rready;
                if (m_rvalid && s_rready && m_rlast) begin
                    r_state_d = R_IDLE;
                end
            end
            R_ERR: begin
                s_rvalid = err_rvalid;
                s_rlast  = err_rlast;
                s_rresp  = RESP_DECERR;
                s_rid    = ar_id_q;
                if (err_done) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_riscv_axi_dram_window.sv
// Scoreboard bench for riscv_axi_dram_window: directed window hits/misses, error bursts and reset.
module tb_riscv_axi_dram_window;
    import riscv_axi_pkg::*;

    localparam int IDW = 6;
    localparam int DW  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IDW-1:0] s_awid, s_arid, s_bid, s_rid, m_awid, m_arid, m_bid, m_rid;
    logic [31:0]    s_awaddr, s_araddr, m_awaddr, m_araddr;
    logic [7:0]     s_awlen, s_arlen, m_awlen, m_arlen;
    logic [2:0]     s_awsize, s_arsize, m_awsize, m_arsize;
    logic [1:0]     s_awburst, s_arburst, m_awburst, m_arburst;
    logic           s_awvalid, s_awready, s_arvalid, s_arready, m_awvalid, m_awready, m_arvalid, m_arready;
    logic [DW-1:0]  s_wdata, m_wdata, s_rdata, m_rdata;
    logic [DW/8-1:0] s_wstrb, m_wstrb;
    logic           s_wlast, s_wvalid, s_wready, m_wlast, m_wvalid, m_wready;
    logic [1:0]     s_bresp, m_bresp, s_rresp, m_rresp;
    logic           s_bvalid, s_bready, m_bvalid, m_bready;
    logic           s_rlast, s_rvalid, s_rready, m_rlast, m_rvalid, m_rready;
    logic           dec_err;

    riscv_axi_dram_window #(
        .C_CORE_BASE (32'h8000_0000),
        .C_DRAM_BASE (32'h3E00_0000),
        .C_DRAM_BITS (24)
    ) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .dec_err(dec_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q[$];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [127:0] got);
        if (exp_q.size() == 0) begin
            check_val({tag, "_underflow"}, 128'(exp_q.size()), 128'd1);
        end else begin
            check_val(tag, got, exp_q.pop_front());
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] w_word(input logic [63:0] d, input logic [7:0] s, input logic l);
        return {55'd0, l, s, d};
    endfunction

    function automatic logic [127:0] r_word(input logic [5:0] id, input logic [1:0] resp,
                                            input logic l, input logic [63:0] d);
        return {55'd0, id, resp, l, d};
    endfunction

    int beats, n;
    logic saw_mar, saw_mw;

    initial begin
        {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid} = '0;
        {s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready} = '0;
        {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready} = '0;
        {m_awready, m_wready, m_bid, m_bresp, m_bvalid, m_arready} = '0;
        {m_rid, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;

        // Reset state
        repeat (3) cyc();
        check_val("rst_awready", s_awready, 0);
        check_val("rst_arready", s_arready, 0);
        check_val("rst_dec_err", dec_err, 0);
        check_val("rst_m_awvalid", m_awvalid, 0);
        rst_n = 1'b1;
        cyc();
        check_val("post_rst_awready", s_awready, 1);
        check_val("post_rst_arready", s_arready, 1);

        // In-window write, len=3
        s_awvalid = 1; s_awid = 6'h2A; s_awaddr = 32'h8000_1000; s_awlen = 8'd3;
        s_awsize = 3'd3; s_awburst = BURST_INCR;
        #1 check_val("wr_awready", s_awready, 1);
        cyc(); s_awvalid = 0; m_awready = 1;
        #1;
        check_val("wr_m_awvalid", m_awvalid, 1);
        check_val("wr_m_awaddr", m_awaddr, 32'h3E00_1000);
        check_val("wr_m_awlen", m_awlen, 3);
        check_val("wr_m_awid", m_awid, 6'h2A);
        check_val("wr_m_awburst", m_awburst, BURST_INCR);
        check_val("wr_wready_addr", s_wready, 0);
        cyc(); m_awready = 0;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(w_word(64'hA5A5_0F0F_0000_0000 | 64'(i * 7 + 1), 8'hF0 | 8'(i), i == 3));
        beats = 0; n = 0;
        while (beats < 4 && n < 80) begin
            s_wvalid = 1;
            s_wdata  = 64'hA5A5_0F0F_0000_0000 | 64'(beats * 7 + 1);
            s_wstrb  = 8'hF0 | 8'(beats);
            s_wlast  = (beats == 3);
            m_wready = 1'($urandom_range(0, 1));
            #1;
            if (m_wvalid && m_wready) begin
                sb_pop("wr_beat", w_word(m_wdata, m_wstrb, m_wlast));
                beats++;
            end
            cyc(); n++;
        end
        check_val("wr_beat_count", beats, 4);
        check_val("wr_sb_drain", exp_q.size(), 0);
        s_wvalid = 0; m_wready = 0;
        m_bvalid = 1; m_bid = 6'h2A; m_bresp = RESP_OKAY; s_bready = 1;
        #1;
        check_val("wr_bvalid", s_bvalid, 1);
        check_val("wr_bid", s_bid, 6'h2A);
        check_val("wr_bresp", s_bresp, RESP_OKAY);
        check_val("wr_m_bready", m_bready, 1);
        cyc(); m_bvalid = 0; s_bready = 0;
        #1 check_val("wr_idle", s_awready, 1);

        // In-window read at the top of the window
        cyc(); s_arvalid = 1; s_arid = 6'd3; s_araddr = 32'h80FF_FFF8; s_arlen = 0;
        s_arsize = 3'd3; s_arburst = BURST_INCR;
        cyc(); s_arvalid = 0; m_arready = 1;
        #1;
        check_val("rd_m_arvalid", m_arvalid, 1);
        check_val("rd_m_araddr", m_araddr, 32'h3EFF_FFF8);
        check_val("rd_m_arid", m_arid, 3);
        cyc(); m_arready = 0;
        m_rvalid = 1; m_rid = 6'd3; m_rdata = 64'h1122_3344_5566_7788; m_rresp = RESP_OKAY; m_rlast = 1;
        exp_q.push_back(r_word(6'd3, RESP_OKAY, 1'b1, 64'h1122_3344_5566_7788));
        s_rready = 1;
        #1;
        check_val("rd_m_rready", m_rready, 1);
        if (s_rvalid && s_rready) sb_pop("rd_beat", r_word(s_rid, s_rresp, s_rlast, s_rdata));
        check_val("rd_sb_drain", exp_q.size(), 0);
        cyc(); m_rvalid = 0; m_rlast = 0; s_rready = 0;
        #1 check_val("rd_idle", s_arready, 1);

        // Out-of-window read, 256 DECERR beats with random backpressure
        cyc(); s_arvalid = 1; s_arid = 6'd5; s_araddr = 32'h1000_0000; s_arlen = 8'd255;
        for (int i = 0; i < 256; i++) exp_q.push_back(r_word(6'd5, RESP_DECERR, i == 255, 64'd0));
        cyc(); s_arvalid = 0; s_rready = 0;
        #1;
        check_val("erd_dec_err", dec_err, 1);
        check_val("erd_m_arvalid", m_arvalid, 0);
        beats = 0; n = 0; saw_mar = 0;
        while (beats < 256 && n < 3000) begin
            cyc(); s_rready = 1'($urandom_range(0, 1));
            #1;
            if (n == 0) check_val("erd_dec_err_pulse", dec_err, 0);
            if (m_arvalid) saw_mar = 1;
            if (s_rvalid && s_rready) begin
                sb_pop("erd_beat", r_word(s_rid, s_rresp, s_rlast, s_rdata));
                beats++;
            end
            n++;
        end
        check_val("erd_beat_count", beats, 256);
        check_val("erd_sb_drain", exp_q.size(), 0);
        check_val("erd_no_m_ar", saw_mar, 0);
        cyc(); s_rready = 0;
        #1;
        check_val("erd_rvalid_done", s_rvalid, 0);
        check_val("erd_idle", s_arready, 1);

        // Out-of-window write, len=1
        cyc(); s_awvalid = 1; s_awid = 6'd9; s_awaddr = 32'h0; s_awlen = 8'd1;
        cyc(); s_awvalid = 0;
        s_wvalid = 1; s_wdata = 64'hCAFE_0000_0000_0001; s_wstrb = 8'hFF; s_wlast = 0;
        #1;
        check_val("ewr_dec_err", dec_err, 1);
        check_val("ewr_wready0", s_wready, 1);
        check_val("ewr_m_wvalid0", m_wvalid, 0);
        cyc(); s_wdata = 64'hCAFE_0000_0000_0002; s_wlast = 1;
        #1;
        check_val("ewr_m_wvalid1", m_wvalid, 0);
        check_val("ewr_m_wdata1", m_wdata, 0);
        cyc(); s_wvalid = 0; s_wlast = 0; s_bready = 1;
        #1;
        check_val("ewr_bvalid", s_bvalid, 1);
        check_val("ewr_bresp", s_bresp, RESP_DECERR);
        check_val("ewr_bid", s_bid, 9);
        cyc(); s_bready = 0;
        #1;
        check_val("ewr_bvalid_done", s_bvalid, 0);
        check_val("ewr_idle", s_awready, 1);

        // W data presented ahead of AW is stalled until the DRAM AW handshake
        saw_mw = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(); s_wvalid = 1; s_wdata = 64'hDEAD_BEEF_0000_0001; s_wstrb = 8'hFF; s_wlast = 1;
            m_wready = 1;
            #1;
            check_val("early_wready", s_wready, 0);
            if (m_wvalid) saw_mw = 1;
        end
        check_val("early_no_m_w", saw_mw, 0);
        cyc(); s_awvalid = 1; s_awid = 6'd1; s_awaddr = 32'h8000_2000; s_awlen = 0;
        cyc(); s_awvalid = 0; m_awready = 0;
        #1 check_val("early_wready_addr", s_wready, 0);
        cyc(); m_awready = 1;
        #1;
        check_val("early_wready_hs", s_wready, 0);
        check_val("early_m_awaddr", m_awaddr, 32'h3E00_2000);
        cyc(); m_awready = 0;
        #1;
        check_val("early_wready_data", s_wready, 1);
        check_val("early_m_wdata", m_wdata, 64'hDEAD_BEEF_0000_0001);
        cyc(); s_wvalid = 0; s_wlast = 0; m_wready = 0; m_bvalid = 1; m_bid = 6'd1; s_bready = 1;
        #1 check_val("early_bid", s_bid, 1);
        cyc(); m_bvalid = 0; s_bready = 0;

        // Simultaneous write and read misses produce one dec_err pulse
        cyc(); s_awvalid = 1; s_awid = 6'd4; s_awaddr = 32'h0000_4000; s_awlen = 0;
        s_arvalid = 1; s_arid = 6'd6; s_araddr = 32'h2000_0000; s_arlen = 0;
        cyc(); s_awvalid = 0; s_arvalid = 0; s_wvalid = 1; s_wlast = 1; s_rready = 1;
        #1;
        check_val("both_dec_err", dec_err, 1);
        check_val("both_rlast", s_rlast, 1);
        check_val("both_rid", s_rid, 6);
        cyc(); s_wvalid = 0; s_wlast = 0; s_rready = 0; s_bready = 1;
        #1;
        check_val("both_dec_err_pulse", dec_err, 0);
        check_val("both_bresp", s_bresp, RESP_DECERR);
        cyc(); s_bready = 0;

        // Reset during beat 2 of a 4-beat error read
        cyc(); s_arvalid = 1; s_arid = 6'd7; s_araddr = 32'h1000_0000; s_arlen = 8'd3;
        cyc(); s_arvalid = 0; s_rready = 1;
        #1 check_val("rst_mid_beat1", s_rvalid, 1);
        cyc(); rst_n = 0;
        #1;
        check_val("rst_mid_rvalid", s_rvalid, 0);
        check_val("rst_mid_arready", s_arready, 0);
        cyc(); cyc(); s_rready = 0; rst_n = 1;
        #1 check_val("rst_rel_arready", s_arready, 0);
        cyc();
        check_val("rst_rel_arready_clk", s_arready, 1);
        check_val("rst_rel_rvalid", s_rvalid, 0);
        s_arvalid = 1; s_arid = 6'd2; s_araddr = 32'h8000_0040; s_arlen = 0;
        cyc(); s_arvalid = 0; m_arready = 1;
        #1;
        check_val("rst_new_m_arvalid", m_arvalid, 1);
        check_val("rst_new_m_araddr", m_araddr, 32'h3E00_0040);
        cyc(); m_arready = 0;
        m_rvalid = 1; m_rid = 6'd2; m_rdata = 64'h0BAD_F00D_0000_0042; m_rresp = RESP_OKAY; m_rlast = 1;
        exp_q.push_back(r_word(6'd2, RESP_OKAY, 1'b1, 64'h0BAD_F00D_0000_0042));
        s_rready = 1;
        #1;
        if (s_rvalid && s_rready) sb_pop("rst_new_beat", r_word(s_rid, s_rresp, s_rlast, s_rdata));
        check_val("rst_new_sb_drain", exp_q.size(), 0);
        cyc(); m_rvalid = 0; m_rlast = 0; s_rready = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
